// File: rtl/reg_file_shadow.sv
// Accumulator register file with two asynchronous read ports, one write port,
// in-place accumulator ops on RF[0] and a shadow bank driven by a one-entry-per-cycle copy engine.
module reg_file_shadow #(
  parameter int DW     = 8,
  parameter int RAW    = 3,
  parameter int BYPASS = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [RAW-1:0] rf_read_addr_a,
  input  logic [RAW-1:0] rf_read_addr_b,
  input  logic [RAW-1:0] rf_write_addr,
  input  logic           rf_write_en,
  input  logic [DW-1:0]  rf_write_val,
  input  logic [1:0]     rf_acc_op,
  input  logic           rf_save_req,
  input  logic           rf_restore_req,
  output logic [DW-1:0]  rf_read_a_o,
  output logic [DW-1:0]  rf_read_b_o,
  output logic [DW-1:0]  rf_acc_o,
  output logic           rf_busy_o,
  output logic           rf_done_o
);

  localparam int D = 1 << RAW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAVE    = 2'd1,
    S_RESTORE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [RAW-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [DW-1:0]  rf_q [D];
  logic [DW-1:0]  sh_q [D];

  logic           idle_s;
  logic           acc_en_s;
  logic           wr_ok_s;
  logic [DW-1:0]  acc_d;

  // A non-zero acc op owns RF[0]; a same-cycle write to address 0 loses.
  assign idle_s   = (state_q == S_IDLE);
  assign acc_en_s = idle_s && (rf_acc_op != 2'b00);
  assign wr_ok_s  = idle_s && rf_write_en &&
                    !((rf_write_addr == {RAW{1'b0}}) && (rf_acc_op != 2'b00));

  always_comb begin
    acc_d = rf_q[0];
    case (rf_acc_op)
      2'b01:   acc_d = {DW{1'b0}};
      2'b10:   acc_d = rf_q[0] + {{(DW-1){1'b0}}, 1'b1};
      2'b11:   acc_d = rf_q[0] - {{(DW-1){1'b0}}, 1'b1};
      default: acc_d = rf_q[0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = {RAW{1'b0}};
        if (rf_save_req) begin
          state_d = S_SAVE;
          busy_d  = 1'b1;
        end else if (rf_restore_req) begin
          state_d = S_RESTORE;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_SAVE, S_RESTORE: begin
        if (cnt_q == {RAW{1'b1}}) begin
          state_d = S_IDLE;
          cnt_d   = {RAW{1'b0}};
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + {{(RAW-1){1'b0}}, 1'b1};
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {RAW{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {RAW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Copy engine moves entry cnt_q each busy cycle; host writes only land while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        rf_q[i] <= {DW{1'b0}};
        sh_q[i] <= {DW{1'b0}};
      end
    end else begin
      case (state_q)
        S_SAVE:    sh_q[cnt_q] <= rf_q[cnt_q];
        S_RESTORE: rf_q[cnt_q] <= sh_q[cnt_q];
        default: begin
          if (wr_ok_s) begin
            rf_q[rf_write_addr] <= rf_write_val;
          end
          if (acc_en_s) begin
            rf_q[0] <= acc_d;
          end
        end
      endcase
    end
  end

  always_comb begin
    rf_read_a_o = rf_q[rf_read_addr_a];
    rf_read_b_o = rf_q[rf_read_addr_b];
    if ((BYPASS != 0) && wr_ok_s && (rf_write_addr == rf_read_addr_a)) begin
      rf_read_a_o = rf_write_val;
    end else begin
      rf_read_a_o = rf_q[rf_read_addr_a];
    end
    if ((BYPASS != 0) && wr_ok_s && (rf_write_addr == rf_read_addr_b)) begin
      rf_read_b_o = rf_write_val;
    end else begin
      rf_read_b_o = rf_q[rf_read_addr_b];
    end
  end

  assign rf_acc_o  = rf_q[0];
  assign rf_busy_o = busy_q;
  assign rf_done_o = done_q;

endmodule

// File: tb/tb_reg_file_shadow.sv
// Directed bench for reg_file_shadow: a behavioural model is checked every cycle,
// plus literal expectations; a BYPASS=0 instance shares the same stimulus.
module tb_reg_file_shadow;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] addr_a = 3'd0, addr_b = 3'd0, waddr = 3'd0;
  logic       wen = 1'b0;
  logic [7:0] wval = 8'h00;
  logic [1:0] op = 2'b00;
  logic       save = 1'b0, restore = 1'b0;

  logic [7:0] ra, rb, acc, ra0, rb0, acc0;
  logic       busy, done, busy0, done0;

  int n_checks = 0;
  int n_errors = 0;
  bit ready = 1'b0;

  reg_file_shadow #(.DW(8), .RAW(3), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rf_read_addr_a(addr_a), .rf_read_addr_b(addr_b),
    .rf_write_addr(waddr), .rf_write_en(wen), .rf_write_val(wval), .rf_acc_op(op),
    .rf_save_req(save), .rf_restore_req(restore), .rf_read_a_o(ra), .rf_read_b_o(rb),
    .rf_acc_o(acc), .rf_busy_o(busy), .rf_done_o(done));

  reg_file_shadow #(.DW(8), .RAW(3), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rf_read_addr_a(addr_a), .rf_read_addr_b(addr_b),
    .rf_write_addr(waddr), .rf_write_en(wen), .rf_write_val(wval), .rf_acc_op(op),
    .rf_save_req(save), .rf_restore_req(restore), .rf_read_a_o(ra0), .rf_read_b_o(rb0),
    .rf_acc_o(acc0), .rf_busy_o(busy0), .rf_done_o(done0));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: copy progress tracked as a mode plus an entry index.
  logic [7:0] m_rf [8];
  logic [7:0] m_sh [8];
  int         m_mode;
  int         m_idx;
  bit         m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_rf[i] <= 8'h00;
        m_sh[i] <= 8'h00;
      end
      m_mode <= 0;
      m_idx  <= 0;
      m_done <= 1'b0;
    end else if (m_mode == 0) begin
      m_done <= 1'b0;
      if (save) m_mode <= 1;
      else if (restore) m_mode <= 2;
      m_idx <= 0;
      if (wen && !(waddr == 3'd0 && op != 2'b00)) m_rf[waddr] <= wval;
      if (op == 2'b01) m_rf[0] <= 8'h00;
      else if (op == 2'b10) m_rf[0] <= m_rf[0] + 8'd1;
      else if (op == 2'b11) m_rf[0] <= m_rf[0] - 8'd1;
    end else begin
      if (m_mode == 1) m_sh[m_idx] <= m_rf[m_idx];
      else m_rf[m_idx] <= m_sh[m_idx];
      m_done <= (m_idx == 7);
      if (m_idx == 7) begin
        m_mode <= 0;
        m_idx  <= 0;
      end else begin
        m_idx <= m_idx + 1;
      end
    end
  end

  function automatic logic [7:0] exp_read(input logic [2:0] a, input bit bypass);
    if (bypass && m_mode == 0 && wen && waddr == a && !(waddr == 3'd0 && op != 2'b00))
      return wval;
    return m_rf[a];
  endfunction

  always @(negedge clk) begin
    if (ready && !reset) begin
      check("read_a", ra, exp_read(addr_a, 1'b1));
      check("read_b", rb, exp_read(addr_b, 1'b1));
      check("acc", acc, m_rf[0]);
      check("busy", {7'd0, busy}, {7'd0, m_mode != 0});
      check("done", {7'd0, done}, {7'd0, m_done});
      check("nb_read_a", ra0, exp_read(addr_a, 1'b0));
      check("nb_read_b", rb0, exp_read(addr_b, 1'b0));
      check("nb_busy", {7'd0, busy0}, {7'd0, m_mode != 0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wen = 1'b0; op = 2'b00; save = 1'b0; restore = 1'b0;
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] v);
    wen = 1'b1; waddr = a; wval = v;
    tick();
    wen = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    check(name, {7'd0, seen}, 8'd1);
  endtask

  logic [7:0] ctx [8];
  int         busy_cnt, done_cnt;

  initial begin
    ctx[0] = 8'h01; ctx[1] = 8'h11; ctx[2] = 8'h22; ctx[3] = 8'h3C;
    ctx[4] = 8'hA5; ctx[5] = 8'h55; ctx[6] = 8'h66; ctx[7] = 8'h77;

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ready = 1'b1;
    check("reset_acc", acc, 8'h00);
    check("reset_read", ra, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'd0);

    for (int i = 1; i < 8; i++) write(3'(i), 8'(8'h11 * i));
    for (int i = 1; i < 8; i++) begin
      addr_a = 3'(i); addr_b = 3'(8 - i);
      #1;
      check("readback_a", ra, 8'(8'h11 * i));
      check("readback_b", rb, 8'(8'h11 * (8 - i)));
      tick();
    end
    check("acc_zero", acc, 8'h00);

    write(3'd0, 8'hFF);
    op = 2'b10; tick(); check("acc_inc_wrap", acc, 8'h00);
    op = 2'b11; tick(); check("acc_dec_wrap", acc, 8'hFF);
    op = 2'b01; tick(); check("acc_clear", acc, 8'h00);

    op = 2'b01; wen = 1'b1; waddr = 3'd0; wval = 8'h5A;
    addr_a = 3'd0;
    #1 check("acc_prio_nofwd", ra, 8'h00);
    tick(); quiet();
    check("acc_prio", acc, 8'h00);
    write(3'd3, 8'h3C);
    addr_a = 3'd3; #1 check("write_3", ra, 8'h3C);

    op = 2'b10; wen = 1'b1; waddr = 3'd5; wval = 8'h55;
    tick(); quiet();
    check("acc_plus_write_acc", acc, 8'h01);
    addr_b = 3'd5; #1 check("acc_plus_write_5", rb, 8'h55);

    addr_a = 3'd4; wen = 1'b1; waddr = 3'd4; wval = 8'hA5;
    #1;
    check("bypass_fwd", ra, 8'hA5);
    check("nobypass_old", ra0, 8'h44);
    tick(); quiet();
    check("nobypass_after", ra0, 8'hA5);

    save = 1'b1; tick(); save = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      tick();
    end
    check("save_busy_cycles", 8'(busy_cnt), 8'd8);
    check("save_done_pulses", 8'(done_cnt), 8'd1);

    for (int i = 0; i < 8; i++) write(3'(i), 8'h00);
    restore = 1'b1; tick(); restore = 1'b0;
    wen = 1'b1; waddr = 3'd2; wval = 8'hEE; op = 2'b10; save = 1'b1;
    repeat (4) tick();
    quiet();
    wait_done("restore_done");
    tick();
    check("restore_no_resave", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      addr_a = 3'(i);
      #1 check("restored", ra, ctx[i]);
    end

    save = 1'b1; tick(); save = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("midreset_acc", acc, 8'h00);
    check("midreset_busy", {7'd0, busy}, 8'd0);
    check("midreset_done", {7'd0, done}, 8'd0);
    check("midreset_read", ra, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    check("postreset_done", {7'd0, done}, 8'd0);
    restore = 1'b1; tick(); restore = 1'b0;
    wait_done("restore2_done");
    tick();
    for (int i = 0; i < 8; i++) begin
      addr_a = 3'(i);
      #1 check("restored_zero", ra, 8'h00);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_shadow.md
# reg_file_shadow

Parametrised accumulator register file for the core datapath: asynchronous reads on two ports plus a dedicated accumulator output, one synchronous write port, and in-place accumulator operations (clear/increment/decrement). A shadow bank is added for context save/restore, handled by a sequential copy engine that moves one register per cycle. It replaces the fixed 8-bit single-read register file and sits between decode and the ALU.

## Interface

- DW, 8, data width of every register
- RAW, 3, address width; depth D = 2**RAW
- BYPASS, 1, 1 = read ports forward an accepted same-cycle write; 0 = no forwarding

- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- rf_read_addr_a  input  RAW  read port A address
- rf_read_addr_b  input  RAW  read port B address
- rf_write_addr  input  RAW  write address
- rf_write_en  input  1  write request
- rf_write_val  input  DW  write data
- rf_acc_op  input  2  00 none, 01 clear, 10 increment, 11 decrement of RF[0]
- rf_save_req  input  1  start a copy of RF into the shadow bank
- rf_restore_req  input  1  start a copy of the shadow bank into RF
- rf_read_a_o  output  DW  read port A data (asynchronous)
- rf_read_b_o  output  DW  read port B data (asynchronous)
- rf_acc_o  output  DW  RF[0], with no forwarding
- rf_busy_o  output  1  copy engine active
- rf_done_o  output  1  one-cycle pulse when a save or restore completes

## Operation

- Storage: RF[0..D-1] and SH[0..D-1], each DW bits. RF[0] is the accumulator.
- Reset values: all RF and SH entries 0, state IDLE, copy counter 0, rf_busy_o 0, rf_done_o 0. All outputs therefore read 0.
- FSM states: IDLE, SAVE, RESTORE.
  - IDLE -> SAVE on rf_save_req.
  - IDLE -> RESTORE on rf_restore_req when rf_save_req is low. If both are high, save wins.
  - SAVE/RESTORE -> IDLE after entry D-1 is copied.
  - Requests that arrive outside IDLE are ignored. They are not queued.
- SAVE: each cycle performs SH[cnt] <= RF[cnt] and cnt <= cnt+1.
- RESTORE: each cycle performs RF[cnt] <= SH[cnt] and cnt <= cnt+1.
- Counter: returns to 0 on completion.
- Writes and accumulator ops are accepted only in IDLE. While busy they are silently dropped, so the snapshot and the restored context stay consistent.
- Reads are legal in every state. During RESTORE they return current RF contents, which may be partially restored.
- Accumulator ops:
  - Increment and decrement wrap modulo 2**DW (0xFF+1 = 0x00, 0x00-1 = 0xFF for DW=8).
  - A non-zero rf_acc_op has priority over a same-cycle write to address 0; that write is discarded.
  - A write to any other address in the same cycle as an acc op completes normally.
- Forwarding (BYPASS=1):
  - Applies when rf_write_en is high, the state is IDLE, the write address matches the read address, and the write is not to address 0 while rf_acc_op is non-zero.
  - The port then returns rf_write_val combinationally.
  - Accumulator results are never forwarded.
  - With BYPASS=0, reads return pre-edge contents.

## Timing

- Read latency is 0 cycles (combinational from address and state). Write and acc-op latency is 1 edge.
- Copy sequence, with a request sampled at edge N:
  - rf_busy_o goes high after edge N.
  - Copies occur at edges N+1 .. N+D.
  - After edge N+D: state IDLE, rf_busy_o low, rf_done_o high for exactly one cycle.
  - A new request may be sampled at edge N+D+1 (while rf_done_o is high).
  - Total blocked window is D cycles.
- rf_busy_o and rf_done_o are registered.
- Reset asserted mid-copy aborts immediately: SH and RF are cleared, rf_done_o is not pulsed, and state is IDLE on deassertion.

## Test plan

- Reset, then write 0x11..0x77 to addresses 1..7, read them back through both ports. Expected: exact values; rf_acc_o = 0.
- Write RF[0]=0xFF, then rf_acc_op=10. Expected: rf_acc_o = 0x00. Then 11: rf_acc_o = 0xFF. Then 01: rf_acc_o = 0x00.
- Same cycle: rf_acc_op=01, write 0x5A to addr 0, write 0x3C to addr 3 on a later cycle. Expected: RF[0]=0x00 (write discarded); RF[3]=0x3C written normally.
- BYPASS=1: write 0xA5 to addr 4 with rf_read_addr_a=4. Expected: rf_read_a_o = 0xA5 in the same cycle. With BYPASS=0 it shows the old value until after the edge.
- Save then restore:
  - Save: rf_busy_o high for 8 cycles, rf_done_o pulses once.
  - Overwrite all registers with 0, then restore.
  - During restore: writes, acc ops and a new save request are ignored.
  - Expected: original values back and rf_done_o pulses once.
- Assert reset at the 4th cycle of a SAVE. Expected: all outputs 0, rf_busy_o 0, no rf_done_o pulse; a subsequent restore yields all-zero RF.
